// File: rtl/cmp_bin_search_pkg.sv
// Shared definitions for the magnitude comparator and its binary-search initiator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cmp_bin_search_pkg;

    // One-hot comparator response, {GT,EQ,LT}, probe relative to target
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

endpackage

// File: rtl/cmp_bin_search.sv
// Binary-search driver for an N-bit comparator: recovers the comparator's hidden operand.
// Latency: a search of P probes (P <= N+1) pulses done P+1 cycles after the start cycle.
// Backpressure: none; start is only accepted while busy=0, otherwise it is dropped.
module cmp_bin_search
    import cmp_bin_search_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   comp_in,
    output logic [N-1:0] probe,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         found,
    output logic         err
);

    // Bounds carry one extra bit so lo can step past the top of the range
    localparam logic [N:0]   MAXV   = {1'b0, {N{1'b1}}};
    localparam logic [N:0]   ONE    = {{N{1'b0}}, 1'b1};
    localparam logic [N-1:0] PROBE0 = {1'b0, {(N-1){1'b1}}};

    state_t       state_q, state_d;
    logic [N:0]   lo_q, lo_d;
    logic [N:0]   hi_q, hi_d;
    logic [N-1:0] probe_d;
    logic         busy_d;
    logic         done_d;
    logic [N-1:0] result_d;
    logic         found_d;
    logic         err_d;

    // Bound update scratch values for the current probe
    logic [N:0]   probe_ext;
    logic [N:0]   lo_upd;
    logic [N:0]   hi_upd;
    logic [N:0]   mid;
    logic         narrow;
    logic         underflow;

    assign probe_ext = {1'b0, probe};

    // Next-state and output decode: accept start in IDLE, narrow or terminate in SEARCH
    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        probe_d   = probe;
        busy_d    = busy;
        done_d    = 1'b0;
        result_d  = result;
        found_d   = found;
        err_d     = err;
        lo_upd    = lo_q;
        hi_upd    = hi_q;
        narrow    = 1'b0;
        underflow = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    lo_d     = '0;
                    hi_d     = MAXV;
                    probe_d  = PROBE0;
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                    result_d = '0;
                    busy_d   = 1'b1;
                    state_d  = SEARCH;
                end
            end
            SEARCH: begin
                case (comp_in)
                    CMP_EQ: begin
                        result_d = probe;
                        found_d  = 1'b1;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = IDLE;
                    end
                    CMP_GT: begin
                        // probe-1 wraps at zero; treat that as an empty range
                        hi_upd    = probe_ext - ONE;
                        underflow = (probe == '0);
                        narrow    = 1'b1;
                    end
                    CMP_LT: begin
                        lo_upd = probe_ext + ONE;
                        narrow = 1'b1;
                    end
                    default: begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                endcase
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Midpoint of the updated bounds becomes the next probe
        mid = lo_upd + ((hi_upd - lo_upd) >> 1);

        if (narrow) begin
            if (underflow || (lo_upd > hi_upd)) begin
                // Target escaped the range: bad comparator or moving target
                err_d   = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end else begin
                lo_d    = lo_upd;
                hi_d    = hi_upd;
                probe_d = N'(mid);
            end
        end
    end

    // State and output registers; reset aborts any search without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            probe   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            found   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            probe   <= probe_d;
            busy    <= busy_d;
            done    <= done_d;
            result  <= result_d;
            found   <= found_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_cmp_bin_search.sv
// Self-checking bench for cmp_bin_search with a behavioural comparator on the probe.
// Latency: checks done arrives P+1 cycles after the start cycle.
// Backpressure: exercises start while busy and start held through done.
module tb_cmp_bin_search;
    import cmp_bin_search_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   comp_in;
    logic [N-1:0] probe;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         found;
    logic         err;

    logic [N-1:0] target = '0;
    logic         fen = 1'b0;
    logic [2:0]   fval = 3'b000;

    cmp_bin_search #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .comp_in (comp_in),
        .probe   (probe),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .found   (found),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Comparator: probe on x, target on y, optionally overridden
    always_comb begin
        if (fen)                 comp_in = fval;
        else if (probe > target) comp_in = CMP_GT;
        else if (probe == target) comp_in = CMP_EQ;
        else                     comp_in = CMP_LT;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0]      target;
        logic              fen;
        logic [2:0]        fval;
        int                np;
        logic [4:0][N-1:0] pr;
        logic [N-1:0]      res;
        logic              fnd;
        logic              er;
    } vec_t;

    typedef struct {
        vec_t v;
        int   st;
        int   idx;
    } exp_t;

    exp_t         exp_q[$];
    logic [N-1:0] obs[$];
    exp_t         mon_e;
    vec_t         vt[10];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [4:0][N-1:0] pk(input logic [N-1:0] a, b, c, d, e);
        pk = {e, d, c, b, a};
    endfunction

    function automatic vec_t mk(input logic [N-1:0] t, input logic fe, input logic [2:0] fv,
                                input int np, input logic [4:0][N-1:0] pr,
                                input logic [N-1:0] res, input logic fnd, input logic er);
        mk.target = t;  mk.fen = fe;  mk.fval = fv;  mk.np = np;
        mk.pr = pr;     mk.res = res; mk.fnd = fnd;  mk.er = er;
    endfunction

    // Scoreboard: collect probes while busy, compare against the oldest expectation on done
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) obs.push_back(probe);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk($sformatf("v%0d_latency", mon_e.idx), cyc - mon_e.st, mon_e.v.np + 1);
                    chk($sformatf("v%0d_nprobes", mon_e.idx), obs.size(), mon_e.v.np);
                    for (int i = 0; i < mon_e.v.np; i++)
                        if (i < obs.size())
                            chk($sformatf("v%0d_probe%0d", mon_e.idx, i), obs[i], mon_e.v.pr[i]);
                    chk($sformatf("v%0d_result", mon_e.idx), result, mon_e.v.res);
                    chk($sformatf("v%0d_found", mon_e.idx), found, mon_e.v.fnd);
                    chk($sformatf("v%0d_err", mon_e.idx), err, mon_e.v.er);
                    chk($sformatf("v%0d_busy", mon_e.idx), busy, 0);
                    chk($sformatf("v%0d_excl", mon_e.idx), found & err, 0);
                end
                obs.delete();
            end
        end
    end

    task automatic push_exp(input int idx);
        exp_t e;
        e.v = vt[idx];
        e.st = cyc;
        e.idx = idx;
        exp_q.push_back(e);
    endtask

    // Drive a one-cycle start for table entry idx and record its expectation
    task automatic launch(input int idx);
        @(negedge clk); #2;
        target = vt[idx].target;
        fen    = vt[idx].fen;
        fval   = vt[idx].fval;
        start  = 1'b1;
        push_exp(idx);
        @(negedge clk); #2;
        start  = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) return;
            @(negedge clk); #2;
        end
        chk("timeout_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_probe"},  probe,  0);
        chk({tag, "_busy"},   busy,   0);
        chk({tag, "_done"},   done,   0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_found"},  found,  0);
        chk({tag, "_err"},    err,    0);
    endtask

    initial begin
        int cnt;
        vt[0] = mk(4'd7,  0, 3'b000, 1, pk(7, 0, 0, 0, 0),     4'd7,  1, 0);
        vt[1] = mk(4'd15, 0, 3'b000, 5, pk(7, 11, 13, 14, 15), 4'd15, 1, 0);
        vt[2] = mk(4'd0,  0, 3'b000, 4, pk(7, 3, 1, 0, 0),     4'd0,  1, 0);
        vt[3] = mk(4'd5,  1, 3'b111, 1, pk(7, 0, 0, 0, 0),     4'd0,  0, 1);
        vt[4] = mk(4'd5,  1, 3'b001, 5, pk(7, 11, 13, 14, 15), 4'd0,  0, 1);
        vt[5] = mk(4'd5,  1, 3'b000, 1, pk(7, 0, 0, 0, 0),     4'd0,  0, 1);
        vt[6] = mk(4'd5,  1, 3'b100, 4, pk(7, 3, 1, 0, 0),     4'd0,  0, 1);
        vt[7] = mk(4'd9,  0, 3'b000, 3, pk(7, 11, 9, 0, 0),    4'd9,  1, 0);
        vt[8] = mk(4'd4,  0, 3'b000, 4, pk(7, 3, 5, 4, 0),     4'd4,  1, 0);
        vt[9] = mk(4'd5,  1, 3'b011, 1, pk(7, 0, 0, 0, 0),     4'd0,  0, 1);

        #2 rst_n = 1'b0;
        #1 chk_reset_vals("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table-driven searches
        for (int k = 0; k < 10; k++) begin
            launch(k);
            wait_idle();
        end

        // start pulsed while busy is ignored; result/found then held while idle
        launch(1);
        @(negedge clk); #2 start = 1'b1;
        @(negedge clk); #2 start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("ignored_start_busy", busy, 0);
        chk("held_result", result, 15);
        chk("held_found", found, 1);

        // start held high through done: next search starts with no idle cycle
        @(negedge clk); #2;
        target = 4'd7; fen = 1'b0; start = 1'b1;
        push_exp(0);
        cnt = 0;
        while (!done && cnt < 20) begin
            @(negedge clk); #2;
            cnt++;
        end
        chk("b2b_first_done_seen", done, 1);
        target = 4'd0;
        push_exp(2);
        @(negedge clk); #2 start = 1'b0;
        wait_idle();

        // Reset during the third probe aborts without a done pulse
        launch(1);
        @(negedge clk);
        @(negedge clk); #2;
        chk("pre_reset_probe", probe, 13);
        rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        exp_q.delete();
        obs.delete();
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #2;
            if (done) cnt++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #2;
            if (done || busy) cnt++;
        end
        chk("no_done_after_reset", cnt, 0);
        launch(7);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d compared expected completion", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
